// File: rtl/jelly_bit_shift_arbiter_pkg.sv
// Shared definitions for the jelly_bit_shift_arbiter slice.
// shift_mode_t names the shifter's operating mode, and shift_mode() selects it
// from the ROTATION/ARITHMETIC parameters. Rotation takes precedence over
// arithmetic fill.
package jelly_bit_shift_arbiter_pkg;

  typedef enum logic [1:0] {
    SHIFT_LOGICAL = 2'd0,
    SHIFT_ARITH   = 2'd1,
    SHIFT_ROTATE  = 2'd2
  } shift_mode_t;

  function automatic shift_mode_t shift_mode(input bit rotation, input bit arithmetic);
    if (rotation)        return SHIFT_ROTATE;
    else if (arithmetic) return SHIFT_ARITH;
    else                 return SHIFT_LOGICAL;
  endfunction

endpackage

// File: rtl/jelly_bit_shift.sv
// Combinational barrel shifter.
//   in_shift  : shift amount; any value is legal
//   in_data   : operand
//   out_data  : shifted or rotated result
// Behaviour by mode:
//   - logical:    zero fill.
//   - arithmetic: a right shift fills with the sign bit, and a left shift fills with zeros.
//   - rotate:     the amount is taken modulo DATA_WIDTH.
// A shift amount of DATA_WIDTH or more gives the fill pattern: zeros, or copies of the sign bit.
module jelly_bit_shift
  import jelly_bit_shift_arbiter_pkg::*;
#(
  parameter int    SHIFT_WIDTH   = 4,
  parameter int    DATA_WIDTH    = (1 << SHIFT_WIDTH),
  parameter int    LEFT          = 0,
  parameter int    ARITHMETIC    = 0,
  parameter int    ROTATION      = 0,
  parameter int    USE_PRIMITIVE = 0,
  parameter string DEVICE        = "RTL"
) (
  input  logic [SHIFT_WIDTH-1:0] in_shift,
  input  logic [DATA_WIDTH-1:0]  in_data,
  output logic [DATA_WIDTH-1:0]  out_data
);

  localparam shift_mode_t MODE = shift_mode(ROTATION != 0, ARITHMETIC != 0);
  localparam bit PRIMITIVE_REQUESTED = (USE_PRIMITIVE != 0) && (DEVICE != "RTL");

  logic [DATA_WIDTH-1:0]   shifted;
  logic [2*DATA_WIDTH-1:0] doubled;
  int unsigned             amount;

  always_comb begin
    shifted = '0;
    doubled = '0;
    amount  = 0;
    case (MODE)
      SHIFT_ROTATE: begin
        amount = in_shift % DATA_WIDTH;
        if (LEFT != 0) begin
          doubled = {in_data, in_data} << amount;
          shifted = doubled[2*DATA_WIDTH-1:DATA_WIDTH];
        end else begin
          doubled = {in_data, in_data} >> amount;
          shifted = doubled[DATA_WIDTH-1:0];
        end
      end
      SHIFT_ARITH: begin
        if (LEFT != 0) shifted = in_data << in_shift;
        else           shifted = $unsigned($signed(in_data) >>> in_shift);
      end
      default: begin
        if (LEFT != 0) shifted = in_data << in_shift;
        else           shifted = in_data >> in_shift;
      end
    endcase
  end

  // This slice has no device primitive library. Both paths therefore use the
  // generic description, and synthesis maps it onto the target's resources.
  if (PRIMITIVE_REQUESTED) begin : g_primitive
    assign out_data = shifted;
  end else begin : g_rtl
    assign out_data = shifted;
  end

endmodule

// File: rtl/jelly_bit_shift_arbiter.sv
// Shares one jelly_bit_shift datapath between NUM requesters.
// Arbitration is round-robin, and the pipeline has two stages: capture, then shift.
// Ports:
//   reset_n, clk, cke             : async active-low reset, clock, clock enable
//   s_shift/s_data/s_valid/s_ready : per-requester request ports (slice i = requester i)
//   m_id/m_data/m_valid/m_ready    : result port, tagged with the requester index
module jelly_bit_shift_arbiter
  import jelly_bit_shift_arbiter_pkg::*;
#(
  parameter int    NUM           = 4,
  parameter int    ID_WIDTH      = 2,
  parameter int    SHIFT_WIDTH   = 4,
  parameter int    DATA_WIDTH    = (1 << SHIFT_WIDTH),
  parameter int    LEFT          = 0,
  parameter int    ARITHMETIC    = 0,
  parameter int    ROTATION      = 0,
  parameter int    USE_PRIMITIVE = 0,
  parameter string DEVICE        = "RTL"
) (
  input  logic                       reset_n,
  input  logic                       clk,
  input  logic                       cke,
  input  logic [NUM*SHIFT_WIDTH-1:0] s_shift,
  input  logic [NUM*DATA_WIDTH-1:0]  s_data,
  input  logic [NUM-1:0]             s_valid,
  output logic [NUM-1:0]             s_ready,
  output logic [ID_WIDTH-1:0]        m_id,
  output logic [DATA_WIDTH-1:0]      m_data,
  output logic                       m_valid,
  input  logic                       m_ready
);

  logic                   st0_valid;
  logic [ID_WIDTH-1:0]    st0_id;
  logic [SHIFT_WIDTH-1:0] st0_shift;
  logic [DATA_WIDTH-1:0]  st0_data;
  logic [ID_WIDTH-1:0]    rr_ptr;

  logic                   stall0, stall1;
  logic [ID_WIDTH:0]      pick;
  logic                   grant_valid;
  logic [ID_WIDTH-1:0]    grant_id;
  logic [ID_WIDTH-1:0]    next_ptr;
  logic                   accept_en;
  logic [SHIFT_WIDTH-1:0] sel_shift;
  logic [DATA_WIDTH-1:0]  sel_data;
  logic [DATA_WIDTH-1:0]  shifted;

  // Returns {found, index}. The first pass scans from ptr up to NUM-1, and the
  // second pass wraps round to 0..ptr-1. Together they give the first asserted
  // index at or after ptr, modulo NUM.
  function automatic logic [ID_WIDTH:0] rr_pick(input logic [NUM-1:0]      valid,
                                                input logic [ID_WIDTH-1:0] ptr);
    logic [ID_WIDTH:0] result;
    result = '0;
    for (int unsigned i = 0; i < NUM; i++) begin
      if (!result[ID_WIDTH] && valid[i] && (ID_WIDTH'(i) >= ptr)) result = {1'b1, ID_WIDTH'(i)};
    end
    for (int unsigned i = 0; i < NUM; i++) begin
      if (!result[ID_WIDTH] && valid[i] && (ID_WIDTH'(i) < ptr)) result = {1'b1, ID_WIDTH'(i)};
    end
    return result;
  endfunction

  assign stall1 = m_valid & ~m_ready;
  assign stall0 = st0_valid & stall1;

  always_comb begin
    pick        = rr_pick(s_valid, rr_ptr);
    grant_valid = pick[ID_WIDTH];
    grant_id    = pick[ID_WIDTH-1:0];
    // reset_n is included so that no requester sees an accept while the pipeline is held in reset.
    accept_en   = cke & reset_n & ~stall0;
    s_ready     = '0;
    sel_shift   = '0;
    sel_data    = '0;
    for (int unsigned i = 0; i < NUM; i++) begin
      if (grant_valid && (grant_id == ID_WIDTH'(i))) begin
        s_ready[i] = accept_en;
        sel_shift  = s_shift[i*SHIFT_WIDTH +: SHIFT_WIDTH];
        sel_data   = s_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    if (int'(grant_id) + 1 >= NUM) next_ptr = '0;
    else                           next_ptr = grant_id + 1'b1;
  end

  jelly_bit_shift #(
    .SHIFT_WIDTH  (SHIFT_WIDTH),
    .DATA_WIDTH   (DATA_WIDTH),
    .LEFT         (LEFT),
    .ARITHMETIC   (ARITHMETIC),
    .ROTATION     (ROTATION),
    .USE_PRIMITIVE(USE_PRIMITIVE),
    .DEVICE       (DEVICE)
  ) u_shift (
    .in_shift(st0_shift),
    .in_data (st0_data),
    .out_data(shifted)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st0_valid <= 1'b0;
      st0_id    <= '0;
      st0_shift <= '0;
      st0_data  <= '0;
      rr_ptr    <= '0;
      m_valid   <= 1'b0;
      m_id      <= '0;
      m_data    <= '0;
    end else if (cke) begin
      if (!stall1) begin
        m_valid <= st0_valid;
        if (st0_valid) begin
          m_id   <= st0_id;
          m_data <= shifted;
        end
      end
      // Whenever st0 loads, any pending request is accepted, so grant_valid is the same as |s_valid.
      if (!stall0) begin
        st0_valid <= grant_valid;
        if (grant_valid) begin
          st0_id    <= grant_id;
          st0_shift <= sel_shift;
          st0_data  <= sel_data;
          rr_ptr    <= next_ptr;
        end
      end
    end
  end

endmodule
